// File: rtl/serial_adder.sv
`default_nettype none
// serial_adder: bit-serial WIDTH-bit adder (two half-adders + carry flop), LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port and a + ~b + 1 subtract mode.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_last;
   logic             w_busy_nxt;
   logic             w_done_nxt;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_cy;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_s;
   logic             r_c;

   logic             w_sub;
   logic             w_hs1;
   logic             w_hc1;
   logic             w_bit;
   logic             w_hc2;
   logic             w_cy_nxt;
   logic [WIDTH-1:0] w_res_nxt;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_sub = sub;
`else
   assign w_sub = 1'b0;
`endif

   // Full adder built from two half-adder stages plus an OR on the carries.
   assign w_hs1     = r_a_sh[0] ^ r_b_sh[0];
   assign w_hc1     = r_a_sh[0] & r_b_sh[0];
   assign w_bit     = w_hs1 ^ r_cy;
   assign w_hc2     = w_hs1 & r_cy;
   assign w_cy_nxt  = w_hc1 | w_hc2;
   assign w_res_nxt = {w_bit, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (r_cnt == C_LAST) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt == RUN);
      w_done_nxt = (w_state_nxt == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh <= '0;
         r_b_sh <= '0;
         r_res  <= '0;
         r_cnt  <= '0;
         r_cy   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_s    <= '0;
         r_c    <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (w_load) begin
            // Subtract loads ~b and presets the carry, giving a + ~b + 1.
            r_a_sh <= a;
            r_b_sh <= w_sub ? ~b : b;
            r_cy   <= w_sub;
            r_res  <= '0;
            r_cnt  <= '0;
         end else if (r_state == RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_cy   <= w_cy_nxt;
            r_res  <= w_res_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
               r_s <= w_res_nxt;
               r_c <= w_cy_nxt;
            end
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign s    = r_s;
   assign c    = r_c;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// tb_serial_adder: randomized scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;

   localparam int W      = 8;
   localparam int MAXCYC = 3 * W + 8;
`ifdef SERIAL_ADDER_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         c;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .s     (s),
      .c     (c)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         acc;
      logic [W:0] sc;
   } exp_t;

   exp_t       sb[$];
   logic [W:0] last_sc = '0;
   int         n_vec = 0;
   int         n_err = 0;
   int         n_cmp = 0;

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic sb_);
      longint unsigned ax, by, mask, t;
      ax   = x;
      by   = y;
      mask = (64'd1 << W) - 1;
      if (sb_) t = ax + ((~by) & mask) + 1;
      else     t = ax + by;
      return t[W:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares the DUT against the expected-result queue every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         chk("reset_outputs", {busy, done, c, s}, '0);
         last_sc = '0;
      end else if (done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 64'(done), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("latency", 64'(cyc), 64'(e.acc + W));
            chk("sum", {c, s}, e.sc);
            chk("busy_with_done", 64'(busy), 64'd0);
            last_sc = e.sc;
         end
      end else begin
         chk("hold", {c, s}, last_sc);
         if (sb.size() != 0 && cyc >= sb[0].acc + W) begin
            chk("done_missing", 64'(done), 64'd1);
            void'(sb.pop_front());
         end else begin
            chk("busy", 64'(busy),
                64'(sb.size() != 0 && cyc >= sb[0].acc && cyc < sb[0].acc + W));
         end
      end
   end

   // Called just after a rising edge with the DUT idle or in DONE.
   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb_,
                     input bit hold);
      exp_t e;
      a     = x;
      b     = y;
      sub   = sb_;
      start = 1'b1;
      e.acc = cyc + 1;
      e.sc  = model(x, y, sb_);
      sb.push_back(e);
      n_vec++;
      if (!hold) begin
         @(posedge clk); #1;
         start = 1'b0;
         a     = W'($urandom);
         b     = W'($urandom);
         sub   = 1'($urandom);
      end
   endtask

   task automatic wait_empty();
      bit fin;
      fin = 1'b0;
      for (int i = 0; i < MAXCYC && !fin; i++) begin
         @(posedge clk); #1;
         if (sb.size() == 0) fin = 1'b1;
      end
      if (!fin) begin
         n_err++;
         $display("FAIL wait_empty: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      logic [W-1:0] x, y, x2, y2;
      logic         sx, sx2;
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start = ~start;
         a     = W'($urandom);
         b     = W'($urandom);
      end
      start = 1'b0;
      rst_n = 1'b1;

      op(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_empty();
      repeat (3) begin @(posedge clk); #1; end

      // Back-to-back: start stays high through DONE with new operands.
      op(8'hA5, 8'h5A, 1'b0, 1'b1);
      repeat (W + 1) begin @(posedge clk); #1; end
      op(8'h80, 8'h80, 1'b0, 1'b0);
      wait_empty();

      // A start pulse during RUN must be ignored.
      op(8'h03, 8'h04, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      wait_empty();

      // Reset mid-RUN abandons the operation and clears s/c.
      op(8'h10, 8'h20, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      sb.delete();
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      op(8'h21, 8'h43, 1'b0, 1'b0);
      wait_empty();

      if (HAS_SUB) begin
         op(8'h05, 8'h07, 1'b1, 1'b0);
         wait_empty();
         op(8'h07, 8'h05, 1'b1, 1'b0);
         wait_empty();
      end

      for (int i = 0; i < 30; i++) begin
         x   = W'($urandom);
         y   = W'($urandom);
         sx  = HAS_SUB ? 1'($urandom) : 1'b0;
         if (i % 3 == 0) begin
            x2  = W'($urandom);
            y2  = W'($urandom);
            sx2 = HAS_SUB ? 1'($urandom) : 1'b0;
            op(x, y, sx, 1'b1);
            repeat (W + 1) begin @(posedge clk); #1; end
            op(x2, y2, sx2, 1'b0);
         end else begin
            op(x, y, sx, 1'b0);
         end
         wait_empty();
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      repeat (3) begin @(posedge clk); #1; end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
